// File: rtl/segment_count_ctrl.sv
// segment_count_ctrl
// Sequences the two-digit seven-segment counter. Switch releases are
// captured as pending events, serialised by a round-robin arbiter and
// applied one at a time to a 0..c_COUNT_LIMIT count kept as BCD digits.
// A programmable lockout (HOLD) follows each applied event.

module segment_count_ctrl #(
    parameter int c_COUNT_LIMIT = 99,
    parameter int c_HOLD_CYCLES = 4
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic [3:0] i_Switches,
    input  logic       i_Ovf_Clr,
    output logic [3:0] o_Tens,
    output logic [3:0] o_Ones,
    output logic [3:0] o_LEDs,
    output logic [3:0] o_Grant,
    output logic       o_Count_Valid,
    output logic       o_Busy,
    output logic       o_Overflow
);

    localparam logic [7:0] c_LIMIT = 8'(c_COUNT_LIMIT);
    localparam logic [7:0] c_HOLD  = 8'(c_HOLD_CYCLES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [3:0]  prev_reg;
    logic [3:0]  pending_reg, pending_next;
    logic [1:0]  ptr_reg, ptr_next;
    logic [7:0]  hold_reg, hold_next;
    logic [7:0]  count_reg, count_next;
    logic [3:0]  tens_reg, ones_reg;
    logic [3:0]  tens_next, ones_next;
    logic [3:0]  leds_reg, leds_next;
    logic [3:0]  grant_reg, grant_next;
    logic        valid_reg, valid_next;
    logic        ovf_reg, ovf_next;

    logic [3:0]  rel_vec;
    logic [3:0]  arb_vec;
    logic [1:0]  arb_idx;
    logic        arb_found;
    logic [3:0]  apply_vec;
    logic [7:0]  op_result;
    logic        ovf_set;

    // Falling edge of each debounced level marks a release
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_rel
            assign rel_vec[gi] = prev_reg[gi] & ~i_Switches[gi];
        end
    endgenerate

    // Round-robin pick: first pending switch at or after the pointer
    always_comb begin
        logic [1:0] idx;
        idx       = 2'd0;
        arb_idx   = 2'd0;
        arb_found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = ptr_reg + 2'(k);
            if (!arb_found && pending_reg[idx]) begin
                arb_found = 1'b1;
                arb_idx   = idx;
            end
        end
        arb_vec = arb_found ? (4'b0001 << arb_idx) : 4'b0000;
    end

    // Modulo (limit+1) arithmetic for the granted switch's operation
    always_comb begin
        op_result = count_reg;
        case (arb_idx)
            2'd0: op_result = (count_reg == c_LIMIT) ? 8'd0 : count_reg + 8'd1;
            2'd1: op_result = (count_reg == 8'd0) ? c_LIMIT : count_reg - 8'd1;
            2'd2: op_result = ((count_reg + 8'd10) > c_LIMIT)
                              ? (count_reg + 8'd10) - (c_LIMIT + 8'd1)
                              : count_reg + 8'd10;
            default: op_result = 8'd0;
        endcase
    end

    // Next-state and datapath updates for the IDLE/APPLY/HOLD sequencer
    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        hold_next  = hold_reg;
        count_next = count_reg;
        leds_next  = leds_reg;
        grant_next = 4'b0000;
        valid_next = 1'b0;
        apply_vec  = 4'b0000;

        case (state_reg)
            IDLE: begin
                if (pending_reg != 4'b0000) begin
                    state_next = APPLY;
                end
            end
            APPLY: begin
                if (arb_found) begin
                    apply_vec  = arb_vec;
                    count_next = op_result;
                    leds_next  = leds_reg ^ arb_vec;
                    grant_next = arb_vec;
                    valid_next = 1'b1;
                    ptr_next   = arb_idx + 2'd1;
                end
                if (c_HOLD == 8'd0) begin
                    // No lockout: chain straight into the next grant
                    state_next = ((pending_reg & ~arb_vec) != 4'b0000) ? APPLY : IDLE;
                end else begin
                    hold_next  = c_HOLD;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                hold_next = hold_reg - 8'd1;
                if (hold_reg <= 8'd1) begin
                    hold_next  = 8'd0;
                    state_next = (pending_reg != 4'b0000) ? APPLY : IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // A release on the switch granted this cycle re-arms it; a release on
        // any other still-pending switch has nowhere to go and is dropped
        pending_next = (pending_reg & ~apply_vec) | rel_vec;
        ovf_set      = |(rel_vec & pending_reg & ~apply_vec);
        ovf_next     = ovf_set | (ovf_reg & ~i_Ovf_Clr);

        tens_next = 4'(count_next / 8'd10);
        ones_next = 4'(count_next % 8'd10);
    end

    // FSM state register
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Event capture, arbitration pointer, hold timer and registered outputs
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            prev_reg    <= 4'b0000;
            pending_reg <= 4'b0000;
            ptr_reg     <= 2'd0;
            hold_reg    <= 8'd0;
            count_reg   <= 8'd0;
            tens_reg    <= 4'd0;
            ones_reg    <= 4'd0;
            leds_reg    <= 4'b0000;
            grant_reg   <= 4'b0000;
            valid_reg   <= 1'b0;
            ovf_reg     <= 1'b0;
        end else begin
            prev_reg    <= i_Switches;
            pending_reg <= pending_next;
            ptr_reg     <= ptr_next;
            hold_reg    <= hold_next;
            count_reg   <= count_next;
            tens_reg    <= tens_next;
            ones_reg    <= ones_next;
            leds_reg    <= leds_next;
            grant_reg   <= grant_next;
            valid_reg   <= valid_next;
            ovf_reg     <= ovf_next;
        end
    end

    assign o_Tens        = tens_reg;
    assign o_Ones        = ones_reg;
    assign o_LEDs        = leds_reg;
    assign o_Grant       = grant_reg;
    assign o_Count_Valid = valid_reg;
    assign o_Overflow    = ovf_reg;
    assign o_Busy        = (state_reg != IDLE) || (pending_reg != 4'b0000);

endmodule
